// File: rtl/bdd_pkg.sv
// Shared types and node-word layout helpers for the BDD / decision-tree traversal engine.
package bdd_pkg;

  typedef enum logic [1:0] {IDLE, FETCH, EVAL, DONE} state_t;

  // Index width for n entries; never below one bit.
  function automatic int idx_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int word_w(int num_attr, int attr_w, int depth);
    return 1 + idx_w(num_attr) + attr_w + 2 * idx_w(depth);
  endfunction

  // Node word, MSB to LSB: is_leaf | attr_idx | threshold | left | right
  function automatic int right_lsb();
    return 0;
  endfunction

  function automatic int left_lsb(int depth);
    return idx_w(depth);
  endfunction

  function automatic int thr_lsb(int depth);
    return 2 * idx_w(depth);
  endfunction

  function automatic int aidx_lsb(int attr_w, int depth);
    return 2 * idx_w(depth) + attr_w;
  endfunction

  function automatic int leaf_bit(int num_attr, int attr_w, int depth);
    return word_w(num_attr, attr_w, depth) - 1;
  endfunction

  // A leaf reuses its {left, right} pointer fields as the class label.
  function automatic logic [63:0] leaf_class(logic [63:0] left_right, int class_w);
    logic [63:0] mask;
    mask = (class_w >= 64) ? '1 : ((64'd1 << class_w) - 64'd1);
    return left_right & mask;
  endfunction

endpackage

// File: rtl/bdd_traverse_engine_if.sv
// Query / result handshake bundle for the traversal engine.
interface bdd_traverse_engine_if #(
  parameter int NUM_ATTR = 8,
  parameter int ATTR_W   = 8,
  parameter int CLASS_W  = 8,
  parameter int MAX_HOPS = 16
);
  localparam int HOPS_W = $clog2(MAX_HOPS + 1);

  logic                       start;
  logic [NUM_ATTR*ATTR_W-1:0] attrs;
  logic                       busy;
  logic                       res_valid;
  logic                       res_ready;
  logic [CLASS_W-1:0]         res_class;
  logic                       res_err;
  logic [HOPS_W-1:0]          res_hops;

  modport master (
    output start, attrs, res_ready,
    input  busy, res_valid, res_class, res_err, res_hops
  );

  modport slave (
    input  start, attrs, res_ready,
    output busy, res_valid, res_class, res_err, res_hops
  );
endinterface

// File: rtl/bdd_node_ram.sv
// Single-port node table with synchronous read; a write also returns the written word.
module bdd_node_ram #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5,
  parameter int WORD_W = 22
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  // Deliberately unreset: the table survives a query abort.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
      rdata     <= wdata;
    end else if (en) begin
      rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/bdd_traverse_engine.sv
// Walks the node table from node 0, one FETCH/EVAL pair per visited node, until a leaf or an error.
module bdd_traverse_engine
  import bdd_pkg::*;
#(
  parameter int NUM_ATTR   = 8,
  parameter int ATTR_W     = 8,
  parameter int DEPTH      = 32,
  parameter int CLASS_W    = 8,
  parameter int MAX_HOPS   = 16,
  localparam int AIDX_W    = idx_w(NUM_ATTR),
  localparam int NODE_W    = idx_w(DEPTH),
  localparam int WORD_W    = word_w(NUM_ATTR, ATTR_W, DEPTH),
  localparam int HOPS_W    = $clog2(MAX_HOPS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [NODE_W-1:0] cfg_addr,
  input  logic [WORD_W-1:0] cfg_data,
  output logic              cfg_drop,
  bdd_traverse_engine_if.slave bus
);

  localparam int R_LSB    = right_lsb();
  localparam int L_LSB    = left_lsb(DEPTH);
  localparam int T_LSB    = thr_lsb(DEPTH);
  localparam int A_LSB    = aidx_lsb(ATTR_W, DEPTH);
  localparam int LEAF_BIT = leaf_bit(NUM_ATTR, ATTR_W, DEPTH);

  state_t                     state;
  logic [NUM_ATTR*ATTR_W-1:0] attrs_q;
  logic [NODE_W-1:0]          ptr;
  logic [HOPS_W-1:0]          hops;
  logic                       busy_q, valid_q, err_q;
  logic [CLASS_W-1:0]         class_q;
  logic [HOPS_W-1:0]          res_hops_q;

  logic                       cfg_ok, ram_en;
  logic [NODE_W-1:0]          ram_addr;
  logic [WORD_W-1:0]          rdata;

  logic                       is_leaf, go_left, bad_aidx, bad_ptr, hop_lim;
  logic [AIDX_W-1:0]          n_aidx;
  logic [ATTR_W-1:0]          n_thr, sel_attr;
  logic [NODE_W-1:0]          n_left, n_right, child;
  logic [HOPS_W-1:0]          hops_nx;

  // A write in the start cycle shares the single port with nothing: the first read is a cycle later.
  assign cfg_ok   = cfg_we && (state == IDLE);
  assign ram_en   = cfg_ok || (state == FETCH);
  assign ram_addr = cfg_ok ? cfg_addr : ptr;

  bdd_node_ram #(.DEPTH(DEPTH), .ADDR_W(NODE_W), .WORD_W(WORD_W)) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (cfg_ok),
    .addr  (ram_addr),
    .wdata (cfg_data),
    .rdata (rdata)
  );

  assign is_leaf = rdata[LEAF_BIT];
  assign n_aidx  = rdata[A_LSB +: AIDX_W];
  assign n_thr   = rdata[T_LSB +: ATTR_W];
  assign n_left  = rdata[L_LSB +: NODE_W];
  assign n_right = rdata[R_LSB +: NODE_W];

  always_comb begin
    sel_attr = '0;
    for (int i = 0; i < NUM_ATTR; i++) begin
      if (n_aidx == AIDX_W'(i)) sel_attr = attrs_q[i*ATTR_W +: ATTR_W];
    end
  end

  assign go_left  = (sel_attr <= n_thr);
  assign child    = go_left ? n_left : n_right;
  assign bad_aidx = (32'(n_aidx) >= NUM_ATTR);
  assign bad_ptr  = (32'(child) >= DEPTH);
  assign hops_nx  = hops + HOPS_W'(1);
  // Reaching the visit budget on an internal node means the next visit would overrun it.
  assign hop_lim  = (32'(hops_nx) >= MAX_HOPS);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      attrs_q    <= '0;
      ptr        <= '0;
      hops       <= '0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      class_q    <= '0;
      res_hops_q <= '0;
      cfg_drop   <= 1'b0;
    end else begin
      cfg_drop <= cfg_we && (state != IDLE);
      case (state)
        IDLE: begin
          if (bus.start) begin
            attrs_q <= bus.attrs;
            busy_q  <= 1'b1;
            ptr     <= '0;
            hops    <= '0;
            state   <= FETCH;
          end
        end
        FETCH: state <= EVAL;
        EVAL: begin
          hops <= hops_nx;
          if (is_leaf) begin
            class_q    <= CLASS_W'(leaf_class(64'({n_left, n_right}), CLASS_W));
            err_q      <= 1'b0;
            res_hops_q <= hops_nx;
            valid_q    <= 1'b1;
            state      <= DONE;
          end else if (bad_aidx || bad_ptr || hop_lim) begin
            class_q    <= '0;
            err_q      <= 1'b1;
            res_hops_q <= hops_nx;
            valid_q    <= 1'b1;
            state      <= DONE;
          end else begin
            ptr   <= child;
            state <= FETCH;
          end
        end
        DONE: begin
          if (bus.res_ready) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.res_valid = valid_q;
  assign bus.res_class = class_q;
  assign bus.res_err   = err_q;
  assign bus.res_hops  = res_hops_q;

endmodule
